// File: rtl/game_event_arbiter.sv
// Merges keyboard events from the user_input FIFO with level-dependent gravity ticks
// into one valid/ack event stream, round-robin arbitrated so neither source starves.
module game_event_arbiter #(
    parameter int         TICK_DIV     = 108000,
    parameter int         BASE_UNITS   = 1000,
    parameter int         STEP_UNITS   = 60,
    parameter int         MIN_UNITS    = 100,
    parameter logic [2:0] GRAVITY_CODE = 3'd3
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] level_i,
    input  logic       game_run_i,
    input  logic [2:0] user_event_i,
    input  logic       user_event_ready_i,
    output logic       user_event_rd_req_o,
    output logic [2:0] event_o,
    output logic       event_valid_o,
    input  logic       event_ack_i
);

    localparam int MAX_UNITS = (BASE_UNITS > MIN_UNITS) ? BASE_UNITS : MIN_UNITS;
    localparam int PRE_W     = $clog2(TICK_DIV + 1);
    localparam int UNIT_W    = $clog2(MAX_UNITS + 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    typedef enum logic {
        SRC_G = 1'b0,
        SRC_U = 1'b1
    } src_e;

    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [UNIT_W-1:0] unit_q, unit_d;
    logic              grav_pend_q, grav_pend_d;
    src_e              last_q, last_d;
    logic              rd_prev_q, rd_prev_d;
    logic [2:0]        event_q, event_d;
    logic              valid_q, valid_d;

    int          period_raw;
    int          period_units;
    logic [31:0] unit_ext;
    logic        pre_wrap;
    logic        expiry;
    logic        slot_free;
    logic        user_avail;
    logic        grav_avail;
    logic        grant_g;
    logic        grant_u;

    // Signed period so that high levels go negative and clamp to the floor.
    always_comb begin
        period_raw   = BASE_UNITS - $signed({28'd0, level_i}) * STEP_UNITS;
        period_units = (period_raw < MIN_UNITS) ? MIN_UNITS : period_raw;
        unit_ext     = 32'(unit_q);
    end

    always_comb begin
        pre_wrap   = (pre_q == PRE_LAST);
        expiry     = game_run_i && pre_wrap && ($signed(unit_ext) >= period_units - 1);
        slot_free  = !valid_q || event_ack_i;
        // The FIFO empty flag lags a pop by a cycle, so never pop back-to-back.
        user_avail = user_event_ready_i && !rd_prev_q;
        grav_avail = grav_pend_q && game_run_i;
        grant_g    = slot_free && grav_avail && (!user_avail || last_q == SRC_U);
        grant_u    = slot_free && user_avail && (!grav_avail || last_q == SRC_G);

        pre_d       = pre_q;
        unit_d      = unit_q;
        grav_pend_d = grav_pend_q;
        last_d      = last_q;
        event_d     = event_q;
        valid_d     = valid_q;
        rd_prev_d   = grant_u;

        if (!game_run_i) begin
            pre_d  = '0;
            unit_d = '0;
        end else if (pre_wrap) begin
            pre_d  = '0;
            unit_d = expiry ? '0 : unit_q + 1'b1;
        end else begin
            pre_d  = pre_q + 1'b1;
        end

        // A fresh expiry beats a same-cycle gravity grant.
        if (!game_run_i) begin
            grav_pend_d = 1'b0;
        end else if (expiry) begin
            grav_pend_d = 1'b1;
        end else if (grant_g) begin
            grav_pend_d = 1'b0;
        end

        if (slot_free) begin
            valid_d = grant_g || grant_u;
            if (grant_g) begin
                event_d = GRAVITY_CODE;
                last_d  = SRC_G;
            end else if (grant_u) begin
                event_d = user_event_i;
                last_d  = SRC_U;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pre_q       <= '0;
            unit_q      <= '0;
            grav_pend_q <= 1'b0;
            last_q      <= SRC_G;
            rd_prev_q   <= 1'b0;
            event_q     <= 3'd0;
            valid_q     <= 1'b0;
        end else begin
            pre_q       <= pre_d;
            unit_q      <= unit_d;
            grav_pend_q <= grav_pend_d;
            last_q      <= last_d;
            rd_prev_q   <= rd_prev_d;
            event_q     <= event_d;
            valid_q     <= valid_d;
        end
    end

    // Gated by reset so nothing is popped while the capture register is held clear.
    assign user_event_rd_req_o = grant_u && rst_i;
    assign event_o             = event_q;
    assign event_valid_o       = valid_q;

endmodule

// File: tb/tb_game_event_arbiter.sv
// Directed bench for game_event_arbiter: a per-cycle vector table for the user
// stream plus hand-written sequences for gravity timing, contention and reset.
module tb_game_event_arbiter;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [3:0] level_i;
    logic       game_run_i;
    logic [2:0] user_event_i;
    logic       user_event_ready_i;
    logic       user_event_rd_req_o;
    logic [2:0] event_o;
    logic       event_valid_o;
    logic       event_ack_i;

    int n_cmp = 0;
    int n_bad = 0;

    game_event_arbiter #(
        .TICK_DIV    (4),
        .BASE_UNITS  (10),
        .STEP_UNITS  (2),
        .MIN_UNITS   (3),
        .GRAVITY_CODE(3'd3)
    ) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .level_i            (level_i),
        .game_run_i         (game_run_i),
        .user_event_i       (user_event_i),
        .user_event_ready_i (user_event_ready_i),
        .user_event_rd_req_o(user_event_rd_req_o),
        .event_o            (event_o),
        .event_valid_o      (event_valid_o),
        .event_ack_i        (event_ack_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic       ready;
        logic [2:0] ev;
        logic       ack;
        logic       exp_rd;
        logic       exp_valid;
        logic [2:0] exp_ev;
    } vec_t;

    vec_t tbl [12];
    logic [2:0] codes [5];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic do_reset();
        rst_i              = 1'b0;
        game_run_i         = 1'b0;
        level_i            = 4'd0;
        event_ack_i        = 1'b0;
        user_event_ready_i = 1'b0;
        user_event_i       = 3'd0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    // Counts rising edges until event_valid_o is seen; -1 if the budget runs out.
    task automatic wait_valid(input int max_cyc, output int n);
        n = -1;
        for (int c = 1; c <= max_cyc; c++) begin
            @(posedge clk_i);
            #1;
            if (event_valid_o) begin
                n = c;
                break;
            end
        end
    endtask

    initial begin
        int n;
        int cnt;
        int cidx;
        bit exp_u;

        // ready, ev, ack, exp_rd, exp_valid, exp_ev
        tbl[0]  = '{1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0};
        tbl[1]  = '{1'b1, 3'd1, 1'b1, 1'b1, 1'b0, 3'd0};
        tbl[2]  = '{1'b1, 3'd2, 1'b1, 1'b0, 1'b1, 3'd1};
        tbl[3]  = '{1'b1, 3'd2, 1'b0, 1'b1, 1'b0, 3'd1};
        tbl[4]  = '{1'b1, 3'd4, 1'b0, 1'b0, 1'b1, 3'd2};
        tbl[5]  = '{1'b1, 3'd4, 1'b0, 1'b0, 1'b1, 3'd2};
        tbl[6]  = '{1'b1, 3'd4, 1'b1, 1'b1, 1'b1, 3'd2};
        tbl[7]  = '{1'b1, 3'd5, 1'b1, 1'b0, 1'b1, 3'd4};
        tbl[8]  = '{1'b1, 3'd5, 1'b1, 1'b1, 1'b0, 3'd4};
        tbl[9]  = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd5};
        tbl[10] = '{1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 3'd5};
        tbl[11] = '{1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 3'd5};
        codes = '{3'd1, 3'd2, 3'd4, 3'd5, 3'd6};

        // Reset state
        do_reset();
        #1;
        chk("rst_valid", int'(event_valid_o), 0);
        chk("rst_event", int'(event_o), 0);
        chk("rst_rd_req", int'(user_event_rd_req_o), 0);

        // User stream with backpressure, gravity off
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_i);
            user_event_ready_i = tbl[i].ready;
            user_event_i       = tbl[i].ev;
            event_ack_i        = tbl[i].ack;
            #1;
            chk($sformatf("vec%0d_rd_req", i), int'(user_event_rd_req_o), int'(tbl[i].exp_rd));
            chk($sformatf("vec%0d_valid", i), int'(event_valid_o), int'(tbl[i].exp_valid));
            chk($sformatf("vec%0d_event", i), int'(event_o), int'(tbl[i].exp_ev));
        end

        // Gravity at level 0: 41 cycles to first event, then every 40
        do_reset();
        event_ack_i = 1'b1;
        game_run_i  = 1'b1;
        wait_valid(60, n);
        chk("lvl0_first_latency", n, 41);
        chk("lvl0_first_code", int'(event_o), 3);
        wait_valid(60, n);
        chk("lvl0_period", n, 40);
        chk("lvl0_second_code", int'(event_o), 3);

        // Period clamp at level 5 (3 units = 12 cycles)
        @(negedge clk_i);
        game_run_i = 1'b0;
        @(negedge clk_i);
        level_i    = 4'd5;
        game_run_i = 1'b1;
        wait_valid(30, n);
        chk("clamp_first_latency", n, 13);
        wait_valid(30, n);
        chk("clamp_period", n, 12);

        // Drop level 0 -> 5 during unit 6: expiry at the next prescaler wrap
        @(negedge clk_i);
        game_run_i = 1'b0;
        @(negedge clk_i);
        level_i    = 4'd0;
        game_run_i = 1'b1;
        repeat (25) @(posedge clk_i);
        @(negedge clk_i);
        level_i = 4'd5;
        wait_valid(30, n);
        chk("midperiod_switch_latency", n, 4);

        // Contention: first grant U, then alternating G,U,G,U,...
        do_reset();
        game_run_i         = 1'b1;
        level_i            = 4'd5;
        user_event_ready_i = 1'b1;
        user_event_i       = codes[0];
        #1;
        chk("cont_first_rd_req", int'(user_event_rd_req_o), 1);
        @(posedge clk_i);
        #1;
        chk("cont_first_valid", int'(event_valid_o), 1);
        chk("cont_first_event", int'(event_o), int'(codes[0]));
        cidx = 1;
        @(negedge clk_i);
        user_event_i = codes[cidx];
        for (int k = 0; k < 6; k++) begin
            exp_u = (k % 2 == 1);
            repeat (13) @(posedge clk_i);
            @(negedge clk_i);
            event_ack_i = 1'b1;
            #1;
            chk($sformatf("cont%0d_rd_req", k), int'(user_event_rd_req_o), int'(exp_u));
            @(posedge clk_i);
            #1;
            chk($sformatf("cont%0d_event", k), int'(event_o), exp_u ? int'(codes[cidx]) : 3);
            @(negedge clk_i);
            event_ack_i = 1'b0;
            if (exp_u) begin
                cidx++;
                user_event_i = codes[cidx];
            end
        end

        // Backpressure: gravity event held 100 cycles, then exactly one more
        do_reset();
        game_run_i = 1'b1;
        level_i    = 4'd5;
        wait_valid(30, n);
        chk("bp_first_latency", n, 13);
        @(negedge clk_i);
        user_event_ready_i = 1'b1;
        user_event_i       = 3'd2;
        cnt = 0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk_i);
            #1;
            if (!event_valid_o || event_o != 3'd3 || user_event_rd_req_o) cnt++;
        end
        chk("bp_hold_bad_cycles", cnt, 0);
        @(negedge clk_i);
        event_ack_i        = 1'b1;
        user_event_ready_i = 1'b0;
        cnt = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (event_valid_o && event_ack_i) cnt++;
            @(negedge clk_i);
        end
        chk("bp_release_handshakes", cnt, 2);

        // Stop with gravity pending: nothing issued, counters restart
        do_reset();
        game_run_i = 1'b1;
        level_i    = 4'd5;
        wait_valid(30, n);
        chk("stop_first_latency", n, 13);
        repeat (13) @(posedge clk_i);
        @(negedge clk_i);
        game_run_i  = 1'b0;
        event_ack_i = 1'b1;
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk_i);
            #1;
            if (event_valid_o) cnt++;
        end
        chk("stop_valid_cycles", cnt, 0);
        @(negedge clk_i);
        game_run_i = 1'b1;
        wait_valid(30, n);
        chk("rerun_latency", n, 13);

        // Reset while an event is held
        do_reset();
        game_run_i = 1'b1;
        wait_valid(60, n);
        chk("prerst_latency", n, 41);
        @(negedge clk_i);
        rst_i              = 1'b0;
        user_event_ready_i = 1'b1;
        user_event_i       = 3'd5;
        #1;
        chk("midrst_valid", int'(event_valid_o), 0);
        chk("midrst_event", int'(event_o), 0);
        chk("midrst_rd_req", int'(user_event_rd_req_o), 0);
        repeat (3) @(negedge clk_i);
        user_event_ready_i = 1'b0;
        rst_i              = 1'b1;
        wait_valid(60, n);
        chk("postrst_latency", n, 41);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
